// File: rtl/psram_quad_writer.sv
// psram_quad_writer: QSPI Quad Write (opcode CMD_WR) frame generator.
// Takes one 1/2/4-byte write request and sends it to the PSRAM pins as
// command, 24-bit address and data, with sck = HCLK/2.
// Optional macro PSRAM_WR_QPI_EN: the device is in QPI mode, so the command
// goes out as two nibbles instead of eight serial bits on dout[0].
// Back-to-back timing: ce_n stays high exactly CEN_GAP cycles between frames.
// busy drops in the last of those cycles so that a waiting start is captured
// there and the next frame starts right when the gap has elapsed.
module psram_quad_writer #(
  parameter logic [7:0]  CMD_WR  = 8'h38,
  parameter int unsigned CEN_GAP = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dout,
  output logic [3:0]  douten
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STOP, GAP} state_t;

`ifdef PSRAM_WR_QPI_EN
  localparam logic       CMD_SERIAL = 1'b0;
  localparam logic [4:0] CMD_LEN    = 5'd2;
`else
  localparam logic       CMD_SERIAL = 1'b1;
  localparam logic [4:0] CMD_LEN    = 5'd8;
`endif
  // ce_n-high cycles still to come after the done cycle
  localparam logic [3:0] GAP_LAST = 4'(CEN_GAP - 1);

  state_t      state_q, state_d;
  logic [63:0] sr_q, sr_d;       // symbols not yet driven, MSB first
  logic [4:0]  cnt_q, cnt_d;     // sck periods left in the current phase
  logic [4:0]  dlen_q, dlen_d;   // data phase length in sck periods (2N)
  logic [3:0]  gap_q, gap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sck_q, sck_d;
  logic        ce_n_q, ce_n_d;
  logic [3:0]  dout_q, dout_d;
  logic [3:0]  douten_q, douten_d;
  logic [63:0] load;
  logic        emit;

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    dlen_d   = dlen_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sck_d    = 1'b0;
    ce_n_d   = ce_n_q;
    dout_d   = dout_q;
    douten_d = douten_q;
    emit     = 1'b0;
    // data bytes are reordered so lane 0 leaves first, high nibble first
    load = {CMD_WR, addr, data[7:0], data[15:8], data[23:16], data[31:24]};

    case (state_q)
      CMD, ADDR, DATA: begin
        if (!sck_q) begin
          sck_d = 1'b1;
        end else if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          emit  = 1'b1;
        end else if (state_q == CMD) begin
          state_d = ADDR;
          cnt_d   = 5'd5;
          emit    = 1'b1;
        end else if (state_q == ADDR) begin
          state_d = DATA;
          cnt_d   = dlen_q - 5'd1;
          emit    = 1'b1;
        end else begin
          // last sck high phase done: release the device this cycle
          state_d  = STOP;
          ce_n_d   = 1'b1;
          douten_d = 4'h0;
          dout_d   = 4'h0;
          done_d   = 1'b1;
          gap_d    = GAP_LAST;
          busy_d   = (GAP_LAST != 4'd0);
        end
      end
      default: begin
        ce_n_d   = 1'b1;
        douten_d = 4'h0;
        dout_d   = 4'h0;
        if (gap_q != 4'd0) begin
          gap_d   = gap_q - 4'd1;
          busy_d  = (gap_q != 4'd1);
          state_d = GAP;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        if (start && !busy_q) begin
          state_d  = CMD;
          busy_d   = 1'b1;
          ce_n_d   = 1'b0;
          douten_d = 4'hF;
          gap_d    = 4'd0;
          cnt_d    = CMD_LEN - 5'd1;
          case (size)
            2'd0:    dlen_d = 5'd2;
            2'd1:    dlen_d = 5'd4;
            default: dlen_d = 5'd8;
          endcase
          if (CMD_SERIAL) begin
            dout_d = {3'b000, load[63]};
            sr_d   = {load[62:0], 1'b0};
          end else begin
            dout_d = load[63:60];
            sr_d   = {load[59:0], 4'h0};
          end
        end
      end
    endcase

    // new symbol goes out on the sck falling edge only
    if (emit) begin
      if (CMD_SERIAL && state_d == CMD) begin
        dout_d = {3'b000, sr_q[63]};
        sr_d   = {sr_q[62:0], 1'b0};
      end else begin
        dout_d = sr_q[63:60];
        sr_d   = {sr_q[59:0], 4'h0};
      end
    end
  end

  // State and registered pin outputs; reset aborts any frame immediately
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      dlen_q   <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sck_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      dout_q   <= 4'h0;
      douten_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      dlen_q   <= dlen_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sck_q    <= sck_d;
      ce_n_q   <= ce_n_d;
      dout_q   <= dout_d;
      douten_q <= douten_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign sck    = sck_q;
  assign ce_n   = ce_n_q;
  assign dout   = dout_q;
  assign douten = douten_q;

endmodule

// File: tb/tb_psram_quad_writer.sv
// tb_psram_quad_writer: directed + randomized writes, pin activity decoded
// by a sampling monitor and compared with a frame-level reference model.
module tb_psram_quad_writer;
  localparam int GAP = 2;
`ifdef PSRAM_WR_QPI_EN
  localparam int CLEN = 2;
`else
  localparam int CLEN = 8;
`endif
  localparam logic [7:0] OPC = 8'h38;

  logic        HCLK = 1'b0;
  logic        HRESET, start;
  logic [23:0] addr;
  logic [31:0] data;
  logic [1:0]  size;
  logic        busy, done, sck, ce_n;
  logic [3:0]  dout, douten;

  always #5 HCLK = ~HCLK;

  psram_quad_writer #(.CMD_WR(OPC), .CEN_GAP(GAP)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .addr(addr), .data(data),
    .size(size), .busy(busy), .done(done), .sck(sck), .ce_n(ce_n),
    .dout(dout), .douten(douten)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // pin monitor: samples mid-cycle, records nibbles at each sck rise
  logic [3:0] nibs[$];
  int         frame_len[$];
  logic       prev_ce = 1'b1, prev_sck = 1'b0;
  logic [3:0] prev_dout = 4'h0;
  int low_cyc = 0, hi_run = 0, last_gap = 0, falls = 0, dones = 0;
  int busy_tail = 0, viol = 0;

  always @(negedge HCLK) begin
    if (ce_n === 1'b0) begin
      low_cyc++;
      if (douten !== 4'hF || busy !== 1'b1) viol++;
      if (prev_ce) begin
        falls++;
        last_gap = hi_run;
        if (sck !== 1'b0) viol++;
      end
      if (sck === 1'b1 && !prev_sck) nibs.push_back(dout);
      if (sck === 1'b1 && dout !== prev_dout) viol++;
    end else begin
      if (!prev_ce) begin
        frame_len.push_back(low_cyc);
        low_cyc   = 0;
        hi_run    = 0;
        busy_tail = 0;
      end
      hi_run++;
      if (busy === 1'b1) busy_tail++;
      if (sck !== 1'b0 || douten !== 4'h0 || dout !== 4'h0) viol++;
    end
    if (done === 1'b1) begin
      dones++;
      if (!(ce_n === 1'b1 && !prev_ce)) viol++;
    end
    prev_ce   = (ce_n !== 1'b0);
    prev_sck  = (sck === 1'b1);
    prev_dout = dout;
  end

  // reference model: expected nibble stream and frame length per request
  logic [3:0] exp_n[$];
  int         exp_len[$];

  task automatic model(input logic [23:0] a, input logic [31:0] d, input logic [1:0] s);
    int nb;
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
`ifdef PSRAM_WR_QPI_EN
    exp_n.push_back(OPC[7:4]);
    exp_n.push_back(OPC[3:0]);
`else
    for (int i = 7; i >= 0; i--) exp_n.push_back({3'b000, OPC[i]});
`endif
    for (int i = 5; i >= 0; i--) exp_n.push_back(a[4*i +: 4]);
    for (int b = 0; b < nb; b++) begin
      exp_n.push_back(d[8*b+4 +: 4]);
      exp_n.push_back(d[8*b +: 4]);
    end
    exp_len.push_back(2 * (CLEN + 6 + 2*nb));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge HCLK);
  endtask

  task automatic issue(input logic [23:0] a, input logic [31:0] d, input logic [1:0] s);
    wait_idle();
    addr = a; data = d; size = s; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    addr = 24'($urandom); data = $urandom; size = 2'($urandom);
  endtask

  task automatic wait_dones(input int target);
    for (int i = 0; i < 400 && dones < target; i++) @(negedge HCLK);
  endtask

  task automatic check_frames(input string tag, input int nb0, input int f0);
    chk({tag, "_nrise"}, nibs.size() - nb0, exp_n.size());
    for (int i = 0; i < exp_n.size(); i++)
      if (nb0 + i < nibs.size())
        chk($sformatf("%s_nib%0d", tag, i), nibs[nb0+i], exp_n[i]);
    chk({tag, "_nframes"}, frame_len.size() - f0, exp_len.size());
    for (int j = 0; j < exp_len.size(); j++)
      if (f0 + j < frame_len.size())
        chk($sformatf("%s_flen%0d", tag, j), frame_len[f0+j], exp_len[j]);
  endtask

  task automatic run_one(input string tag, input logic [23:0] a, input logic [31:0] d,
                         input logic [1:0] s, input bit mid);
    int nb0, f0, d0, fa0, v0;
    nb0 = nibs.size(); f0 = frame_len.size(); d0 = dones; fa0 = falls; v0 = viol;
    exp_n.delete(); exp_len.delete();
    model(a, d, s);
    issue(a, d, s);
    if (mid) begin
      // strobe while busy: must be dropped
      repeat (5) @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
    end
    wait_dones(d0 + 1);
    repeat (GAP + 4) @(negedge HCLK);
    check_frames(tag, nb0, f0);
    chk({tag, "_dones"}, dones - d0, 1);
    chk({tag, "_falls"}, falls - fa0, 1);
    chk({tag, "_pinrules"}, viol - v0, 0);
    chk({tag, "_busytail"}, busy_tail, GAP - 1);
  endtask

  initial begin
    int nb0, f0, d0, fa0, v0;
    logic [23:0] ra;
    logic [31:0] rd;
    HRESET = 1'b1; start = 1'b0; addr = '0; data = '0; size = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sck", sck, 0);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_dout", dout, 0);
    chk("rst_douten", douten, 0);
    HRESET = 1'b0;
    @(negedge HCLK);

    run_one("word0", 24'h000000, 32'hABCD1234, 2'd2, 1'b0);
    run_one("byte201", 24'd201, 32'h00000032, 2'd0, 1'b0);
    run_one("half300", 24'd300, 32'h0000BBAA, 2'd1, 1'b1);
    run_one("size3", 24'hFFFFFF, 32'h89ABCDEF, 2'd3, 1'b0);

    for (int k = 0; k < 12; k++) begin
      ra = 24'($urandom);
      rd = $urandom;
      run_one($sformatf("rnd%0d", k), ra, rd, 2'($urandom), 1'($urandom));
    end

    // back-to-back with start held high across the gap
    nb0 = nibs.size(); f0 = frame_len.size(); d0 = dones; fa0 = falls; v0 = viol;
    exp_n.delete(); exp_len.delete();
    model(24'h123456, 32'hCAFEF00D, 2'd2);
    model(24'h00ABCD, 32'h00005A3C, 2'd1);
    wait_idle();
    addr = 24'h123456; data = 32'hCAFEF00D; size = 2'd2; start = 1'b1;
    for (int i = 0; i < 20 && falls == fa0; i++) @(negedge HCLK);
    @(negedge HCLK);
    addr = 24'h00ABCD; data = 32'h00005A3C; size = 2'd1;
    for (int i = 0; i < 200 && falls < fa0 + 2; i++) @(negedge HCLK);
    @(negedge HCLK);
    start = 1'b0;
    wait_dones(d0 + 2);
    repeat (GAP + 4) @(negedge HCLK);
    check_frames("b2b", nb0, f0);
    chk("b2b_gap", last_gap, GAP);
    chk("b2b_dones", dones - d0, 2);
    chk("b2b_pinrules", viol - v0, 0);

    // reset in the data phase aborts the frame with no done
    nb0 = nibs.size(); d0 = dones; fa0 = falls;
    issue(24'h0F0F0F, 32'h76543210, 2'd2);
    for (int i = 0; i < 200 && (nibs.size() - nb0) < CLEN + 6 + 2; i++) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("abort_ce_n", ce_n, 1);
    chk("abort_sck", sck, 0);
    chk("abort_douten", douten, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    HRESET = 1'b0;
    repeat (20) @(negedge HCLK);
    chk("abort_nodone", dones - d0, 0);
    chk("abort_falls", falls - fa0, 1);
    run_one("post_rst", 24'h0000C9, 32'hABCD1234, 2'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
